// File: rtl/controle_pkg.sv
// Shared types and default timing constants for the manoeuvre controller.
package controle_pkg;

    // State codes are also exported on the Estado debug port.
    typedef enum logic [2:0] {
        PARADO    = 3'd0,
        FRENTE    = 3'd1,
        RE        = 3'd2,
        GIRO_DIR  = 3'd3,
        GIRO_ESQ  = 3'd4,
        BLOQUEADO = 3'd5,
        ERRO      = 3'd6
    } estado_t;

    localparam int FILTRO_PADRAO     = 4;
    localparam int TEMPO_RE_PADRAO   = 50;
    localparam int TEMPO_GIRO_PADRAO = 25;

    // Larger of two integers, used to size the shared manoeuvre counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/filtro_sensor.sv
// Debounce filter for one proximity sensor: the output only follows the raw
// input after FILTRO consecutive samples that disagree with the current output.
module filtro_sensor #(
    parameter int FILTRO = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic entrada,
    output logic saida
);

    localparam int CW = (FILTRO > 1) ? $clog2(FILTRO) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(FILTRO - 1);

    logic          saida_q, saida_d;
    logic [CW-1:0] conta_q, conta_d;

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        saida_d = saida_q;
        conta_d = '0;
        if (entrada != saida_q) begin
            if (conta_q == LIMITE) begin
                saida_d = entrada;
                conta_d = '0;
            end else begin
                conta_d = conta_q + 1'b1;
            end
        end
    end

    // Filter state register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            saida_q <= 1'b0;
            conta_q <= '0;
        end else begin
            saida_q <= saida_d;
            conta_q <= conta_d;
        end
    end

    assign saida = saida_q;

endmodule

// File: rtl/controle_manobra.sv
// Obstacle-avoidance sequencer: filters the four sensors, runs timed and
// mutually exclusive manoeuvres, and decodes motor/steering enables from state.
module controle_manobra
    import controle_pkg::*;
#(
    parameter int FILTRO     = FILTRO_PADRAO,
    parameter int TEMPO_RE   = TEMPO_RE_PADRAO,
    parameter int TEMPO_GIRO = TEMPO_GIRO_PADRAO
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Ligar,
    input  logic       Sensor_Frontal,
    input  logic       Sensor_Direito,
    input  logic       Sensor_Esquerdo,
    input  logic       Sensor_Trazeiro,
    input  logic       Saida_Erro,
    output logic       Motor_Frente,
    output logic       Motor_Re,
    output logic       Virar_Direita,
    output logic       Virar_Esquerda,
    output logic       Bloqueado,
    output logic [2:0] Estado
);

    localparam int TEMPO_MAX = max_int(TEMPO_RE, TEMPO_GIRO);
    localparam int CW        = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;
    localparam logic [CW-1:0] FIM_RE   = CW'(TEMPO_RE - 1);
    localparam logic [CW-1:0] FIM_GIRO = CW'(TEMPO_GIRO - 1);

    logic f_filt, d_filt, e_filt, t_filt;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] contador_q, contador_d;

    filtro_sensor #(.FILTRO(FILTRO)) u_filtro_frontal (
        .Clock   (Clock),
        .Reset   (Reset),
        .entrada (Sensor_Frontal),
        .saida   (f_filt)
    );

    filtro_sensor #(.FILTRO(FILTRO)) u_filtro_direito (
        .Clock   (Clock),
        .Reset   (Reset),
        .entrada (Sensor_Direito),
        .saida   (d_filt)
    );

    filtro_sensor #(.FILTRO(FILTRO)) u_filtro_esquerdo (
        .Clock   (Clock),
        .Reset   (Reset),
        .entrada (Sensor_Esquerdo),
        .saida   (e_filt)
    );

    filtro_sensor #(.FILTRO(FILTRO)) u_filtro_trazeiro (
        .Clock   (Clock),
        .Reset   (Reset),
        .entrada (Sensor_Trazeiro),
        .saida   (t_filt)
    );

    // Pick the free side after reversing; right wins when both are free.
    function automatic estado_t decide_lado(input logic direito, input logic esquerdo);
        if (!direito) begin
            return GIRO_DIR;
        end else if (!esquerdo) begin
            return GIRO_ESQ;
        end else begin
            return BLOQUEADO;
        end
    endfunction

    // Next-state logic: error first, then run enable, then per-state rules.
    always_comb begin
        estado_d = estado_q;
        if (Saida_Erro) begin
            estado_d = ERRO;
        end else if (!Ligar) begin
            estado_d = PARADO;
        end else begin
            unique case (estado_q)
                PARADO:    estado_d = FRENTE;
                FRENTE:    if (f_filt) estado_d = RE;
                RE:        if ((contador_q == FIM_RE) || t_filt)
                               estado_d = decide_lado(d_filt, e_filt);
                GIRO_DIR,
                GIRO_ESQ:  if (contador_q == FIM_GIRO) estado_d = FRENTE;
                BLOQUEADO: if (!d_filt || !e_filt)
                               estado_d = decide_lado(d_filt, e_filt);
                ERRO:      estado_d = ERRO;
                default:   estado_d = PARADO;
            endcase
        end
    end

    // Manoeuvre timer: restarts on any state change, runs only while timed.
    always_comb begin
        contador_d = '0;
        if ((estado_d == estado_q) &&
            ((estado_q == RE) || (estado_q == GIRO_DIR) || (estado_q == GIRO_ESQ))) begin
            contador_d = contador_q + 1'b1;
        end
    end

    // State and timer registers; reset aborts any manoeuvre in progress.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            estado_q   <= PARADO;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
        end
    end

    // Moore output decode straight from the state register.
    always_comb begin
        Motor_Frente   = (estado_q == FRENTE);
        Motor_Re       = (estado_q == RE);
        Virar_Direita  = (estado_q == GIRO_DIR);
        Virar_Esquerda = (estado_q == GIRO_ESQ);
        Bloqueado      = (estado_q == BLOQUEADO);
        Estado         = estado_q;
    end

endmodule

// File: tb/tb_controle_manobra.sv
// Randomised and scenario-driven bench for controle_manobra with a
// cycle-level behavioural model feeding a scoreboard queue.
module tb_controle_manobra;

    localparam int FILTRO     = 4;
    localparam int TEMPO_RE   = 50;
    localparam int TEMPO_GIRO = 25;

    logic       Clock;
    logic       Reset;
    logic       Ligar;
    logic       Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro;
    logic       Saida_Erro;
    logic       Motor_Frente, Motor_Re, Virar_Direita, Virar_Esquerda, Bloqueado;
    logic [2:0] Estado;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit done   = 0;

    logic [7:0] exp_q[$];

    // Model state: mode name as plain int, cycles spent, filter view of sensors.
    int m_mode;
    int m_spent;
    bit m_filt[4];
    int m_run[4];

    controle_manobra #(
        .FILTRO     (FILTRO),
        .TEMPO_RE   (TEMPO_RE),
        .TEMPO_GIRO (TEMPO_GIRO)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Ligar           (Ligar),
        .Sensor_Frontal  (Sensor_Frontal),
        .Sensor_Direito  (Sensor_Direito),
        .Sensor_Esquerdo (Sensor_Esquerdo),
        .Sensor_Trazeiro (Sensor_Trazeiro),
        .Saida_Erro      (Saida_Erro),
        .Motor_Frente    (Motor_Frente),
        .Motor_Re        (Motor_Re),
        .Virar_Direita   (Virar_Direita),
        .Virar_Esquerda  (Virar_Esquerda),
        .Bloqueado       (Bloqueado),
        .Estado          (Estado)
    );

    initial Clock = 1'b0;
    // Free-running 10-unit clock.
    always #5 Clock = ~Clock;

    function automatic logic [7:0] pack_expected(input int mode);
        logic [7:0] v;
        v[7:5] = 3'(mode);
        v[4]   = (mode == 1);
        v[3]   = (mode == 2);
        v[2]   = (mode == 3);
        v[1]   = (mode == 4);
        v[0]   = (mode == 5);
        return v;
    endfunction

    function automatic int side_choice(input bit right_blocked, input bit left_blocked);
        if (!right_blocked) return 3;
        if (!left_blocked)  return 4;
        return 5;
    endfunction

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual=%b expected=%b", name, cycle, actual, expected);
        end
    endtask

    // Behavioural reference: decide using the filtered view held before this
    // edge, then let each sensor's disagreement run advance.
    always @(posedge Clock) begin
        bit raw[4];
        int nxt;
        if (!done) begin
            raw[0] = Sensor_Frontal;
            raw[1] = Sensor_Direito;
            raw[2] = Sensor_Esquerdo;
            raw[3] = Sensor_Trazeiro;
            if (!Reset) begin
                m_mode  = 0;
                m_spent = 0;
                for (int i = 0; i < 4; i++) begin
                    m_filt[i] = 1'b0;
                    m_run[i]  = 0;
                end
            end else begin
                nxt = m_mode;
                if (Saida_Erro) nxt = 6;
                else if (!Ligar) nxt = 0;
                else begin
                    case (m_mode)
                        0: nxt = 1;
                        1: if (m_filt[0]) nxt = 2;
                        2: if ((m_spent + 1 >= TEMPO_RE) || m_filt[3])
                               nxt = side_choice(m_filt[1], m_filt[2]);
                        3, 4: if (m_spent + 1 >= TEMPO_GIRO) nxt = 1;
                        5: if (!m_filt[1] || !m_filt[2])
                               nxt = side_choice(m_filt[1], m_filt[2]);
                        default: nxt = 6;
                    endcase
                end
                m_spent = (nxt == m_mode) ? m_spent + 1 : 0;
                m_mode  = nxt;
                for (int i = 0; i < 4; i++) begin
                    if (raw[i] != m_filt[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= FILTRO) begin
                            m_filt[i] = raw[i];
                            m_run[i]  = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            exp_q.push_back(pack_expected(m_mode));
        end
    end

    // Monitor: every cycle presents a fresh output word, compared mid-cycle.
    always @(negedge Clock) begin
        logic [7:0] e;
        logic [7:0] a;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {Estado, Motor_Frente, Motor_Re, Virar_Direita, Virar_Esquerda, Bloqueado};
            check_output("outputs", a, e);
            check_output("exclusive", {7'd0, ($countones({Motor_Frente, Motor_Re, Virar_Direita, Virar_Esquerda}) > 1)}, 8'd0);
        end
    end

    task automatic apply_stimulus(input bit rst_n, input bit lig, input bit f, input bit d,
                                  input bit e, input bit t, input bit err, input int n);
        Reset           = rst_n;
        Ligar           = lig;
        Sensor_Frontal  = f;
        Sensor_Direito  = d;
        Sensor_Esquerdo = e;
        Sensor_Trazeiro = t;
        Saida_Erro      = err;
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        $display("[TB] start");
        // Reset and start
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 2);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 3);
        // Obstacle with right free
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 6);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 90);
        // Glitch rejection, then left turn
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 3);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 10);
        apply_stimulus(1, 1, 1, 1, 0, 0, 0, 6);
        apply_stimulus(1, 1, 0, 1, 0, 0, 0, 90);
        // Blocked path, then right clears
        apply_stimulus(1, 1, 1, 1, 1, 0, 0, 6);
        apply_stimulus(1, 1, 0, 1, 1, 0, 0, 60);
        apply_stimulus(1, 1, 0, 0, 1, 0, 0, 35);
        // Rear abort during reverse
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 6);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 17);
        apply_stimulus(1, 1, 0, 0, 0, 1, 0, 6);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 40);
        // Error mid-turn, re-arm only with Ligar low
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 6);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 60);
        apply_stimulus(1, 1, 0, 0, 0, 0, 1, 3);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 5);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 2);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 3);
        // Reset mid-reverse, then a full reverse
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 6);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 28);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 3);
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 6);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 90);
        // Randomised segments with varied hold lengths
        for (int k = 0; k < 3000; k++) begin
            apply_stimulus(($urandom_range(0, 99) != 0),
                           ($urandom_range(0, 29) != 0),
                           ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 1) == 0),
                           ($urandom_range(0, 1) == 0),
                           ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 59) == 0),
                           $urandom_range(1, 8));
        end
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 2);
        done = 1;
        repeat (3) @(negedge Clock);
        check_output("drain", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_manobra.md
# controle_manobra

Sequencing controller for the vehicle's obstacle-avoidance manoeuvres. It filters the four proximity sensors and decides every cycle whether the vehicle drives forward, reverses, turns or stops. It drives the motor and steering enables directly, and replaces free-running combinational decisions with timed, mutually exclusive manoeuvres. It sits between the raw sensor and error inputs and the motor drivers.

## Interface
- FILTRO, 4: consecutive equal samples required before a filtered sensor changes (≥1).
- TEMPO_RE, 50: reverse duration in clock cycles (≥1).
- TEMPO_GIRO, 25: turn duration in clock cycles (≥1).
- Clock  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- Ligar  in  1  run enable from operator.
- Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro  in  1 each  raw obstacle sensors, 1 = obstacle.
- Saida_Erro  in  1  system error, 1 = fault.
- Motor_Frente  out  1  drive forward.
- Motor_Re  out  1  drive reverse.
- Virar_Direita, Virar_Esquerda  out  1 each  steering enables.
- Bloqueado  out  1  both sides obstructed after reverse.
- Estado  out  3  current state code, for debug.

## Operation
- States and codes: PARADO=0, FRENTE=1, RE=2, GIRO_DIR=3, GIRO_ESQ=4, BLOQUEADO=5, ERRO=6.
- Outputs are Moore outputs, decoded from the state register only.
  - FRENTE: Motor_Frente=1.
  - RE: Motor_Re=1.
  - GIRO_DIR: Virar_Direita=1.
  - GIRO_ESQ: Virar_Esquerda=1.
  - BLOQUEADO: Bloqueado=1.
  - Every other output is 0 in every state.
  - At most one of Motor_Frente, Motor_Re, Virar_* is ever high.
- Priority applied in every state:
  1. Saida_Erro=1 goes to ERRO. Saida_Erro is raw and unfiltered.
  2. Ligar=0 goes to PARADO.
  3. Otherwise the state-specific rules below apply.
- State-specific rules (F, D, E, T = filtered front, right, left, rear):
  - PARADO: Ligar=1 → FRENTE.
  - FRENTE: F=1 → RE.
  - RE: counter reaches TEMPO_RE−1, or T=1 → side decision.
    - Side decision: D=0 → GIRO_DIR; else E=0 → GIRO_ESQ; else → BLOQUEADO. Right has priority.
  - GIRO_*: counter reaches TEMPO_GIRO−1 → FRENTE.
  - BLOQUEADO: D=0 or E=0 → same side decision as above.
  - ERRO: leave only when Saida_Erro=0 and Ligar=0 → PARADO. The operator must re-arm.
- Manoeuvre counter:
  - Cleared on every state change.
  - Increments while in RE or GIRO_*.
  - Width is $clog2(max(TEMPO_RE,TEMPO_GIRO)).
  - Never wraps, because the state always exits at the terminal count.
- Reset (Reset=0 at an edge):
  - State goes to PARADO, counter to 0.
  - All filtered sensors go to 0, with their filter counts cleared.
  - All outputs are 0 and Estado=0.
  - Reset mid-manoeuvre aborts it with no residual count.

## Timing
- Sensor filter: the filtered value flips at the edge where the raw input has differed from it on FILTRO consecutive edges. Any intermediate agreeing sample restarts the count.
- Sensor-to-output latency:
  - Raw change first sampled at edge k → filtered change after edge k+FILTRO−1.
  - State and outputs change after edge k+FILTRO.
- Error latency: Saida_Erro high before edge k → outputs 0 after edge k, i.e. 1 cycle.
- Ligar latency: 1 cycle.
- Manoeuvre durations:
  - RE holds Motor_Re for exactly TEMPO_RE cycles unless cut short by T, error or Ligar.
  - GIRO_* holds its steering enable for exactly TEMPO_GIRO cycles.
- Simultaneous events:
  - Error overrides everything.
  - In RE, T=1 at the same edge as the terminal count produces a single side decision.
  - In FRENTE, F=1 and Ligar=0 together → PARADO.

## Structure
- Package controle_pkg holds:
  - the state enum (3-bit) with the codes above;
  - the default FILTRO, TEMPO_RE and TEMPO_GIRO constants.
- Sub-module filtro_sensor (parameter FILTRO; ports Clock, Reset, entrada, saida) is instantiated four times, once per sensor.
- The FSM, manoeuvre counter and output decode live in controle_manobra.

## Test plan
All scenarios use FILTRO=4, TEMPO_RE=50, TEMPO_GIRO=25.

- **Reset and start:** Reset=0 for 2 cycles → all outputs 0, Estado=0. Then Ligar=1 → Motor_Frente=1 one cycle later.
- **Obstacle with right free:** in FRENTE, Sensor_Frontal=1 held → Motor_Re=1 exactly 4 edges after the first sample. It lasts 50 cycles, then Virar_Direita=1 for 25 cycles, then Motor_Frente=1.
- **Glitch rejection and left turn:**
  - Sensor_Frontal pulsed high for 3 cycles → no state change.
  - Sensor_Frontal held with D=1, E=0 → after the reverse, Virar_Esquerda=1.
- **Blocked path and rear abort:**
  - D=E=1 at reverse end → Bloqueado=1. Dropping Sensor_Direito to 0 gives Virar_Direita=1 five cycles later.
  - Sensor_Trazeiro=1 filtered at reverse cycle 20 → reverse ends early and the turn starts.
- **Error handling:**
  - Saida_Erro=1 mid-turn → all outputs 0 next cycle, Estado=6.
  - Clearing Saida_Erro with Ligar=1 → stays in ERRO.
  - Ligar=0 → PARADO.
- **Reset mid-reverse:** Reset=0 at reverse cycle 30 → PARADO with outputs 0. After restart, the next reverse lasts the full 50 cycles.
